// File: rtl/knn_pkg.sv
// knn_pkg: shared default widths and the saturated distance tag for the k-NN datapath
package knn_pkg;
    localparam int KNN_DATA_W  = 32;
    localparam int KNN_TAG_W   = 32;
    localparam int KNN_COORD_W = 16;
    localparam int KNN_DIMS    = 2;
    localparam int KNN_DEPTH   = 8;
    // all-ones is the queue's empty-min sentinel, so real distances top out one below it
    localparam logic [KNN_TAG_W-1:0] KNN_SAT_TAG = ~KNN_TAG_W'(1);
endpackage

// File: rtl/dist_sq_pipe.sv
// dist_sq_pipe: three-stage squared Euclidean distance pipeline with per-stage backpressure
module dist_sq_pipe
    import knn_pkg::*;
#(
    parameter int DATA_WIDTH  = KNN_DATA_W,
    parameter int TAG_WIDTH   = KNN_TAG_W,
    parameter int COORD_WIDTH = KNN_COORD_W,
    parameter int DIMS        = KNN_DIMS
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        stall,
    input  logic                        cand_valid,
    input  logic [DATA_WIDTH-1:0]       cand_data,
    input  logic [DIMS*COORD_WIDTH-1:0] cand_coord,
    input  logic [DIMS*COORD_WIDTH-1:0] query,
    output logic                        cand_ready,
    output logic                        res_valid,
    output logic [DATA_WIDTH-1:0]       res_data,
    output logic [TAG_WIDTH-1:0]        res_tag,
    output logic                        busy
);
    localparam int DW  = COORD_WIDTH + 1;
    localparam int SQW = 2 * DW;
    localparam int SW0 = SQW + $clog2(DIMS) + 1;
    localparam int SW  = SW0 > TAG_WIDTH ? SW0 : TAG_WIDTH + 1;
    localparam logic [TAG_WIDTH-1:0] SAT = ~TAG_WIDTH'(1);
    localparam logic [SW-1:0] LIM = SW'({TAG_WIDTH{1'b1}});

    logic                   v1, v2, v3, r1, r2, r3;
    logic [DATA_WIDTH-1:0]  id1, id2, id3;
    logic signed [DW-1:0]   diff1 [DIMS];
    logic signed [DW-1:0]   diff_n [DIMS];
    logic [SQW-1:0]         sq2 [DIMS];
    logic [SQW-1:0]         sq_n [DIMS];
    logic [SW-1:0]          sum_n;
    logic [TAG_WIDTH-1:0]   tag3;

    // a stage may load when empty or when its contents move on this cycle
    assign r3 = !v3 || !stall;
    assign r2 = !v2 || r3;
    assign r1 = !v1 || r2;

    always_comb begin
        sum_n = '0;
        for (int d = 0; d < DIMS; d++) begin
            diff_n[d] = DW'($signed(query[d*COORD_WIDTH +: COORD_WIDTH]))
                      - DW'($signed(cand_coord[d*COORD_WIDTH +: COORD_WIDTH]));
            sq_n[d] = SQW'(diff1[d]) * SQW'(diff1[d]);
            sum_n = sum_n + SW'(sq2[d]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            {v1, v2, v3} <= '0;
            {id1, id2, id3} <= '0;
            tag3 <= '0;
            for (int d = 0; d < DIMS; d++) begin
                diff1[d] <= '0;
                sq2[d] <= '0;
            end
        end else begin
            if (r1) begin
                v1 <= cand_valid;
                if (cand_valid) begin
                    id1 <= cand_data;
                    for (int d = 0; d < DIMS; d++) diff1[d] <= diff_n[d];
                end
            end
            if (r2) begin
                v2 <= v1;
                if (v1) begin
                    id2 <= id1;
                    for (int d = 0; d < DIMS; d++) sq2[d] <= sq_n[d];
                end
            end
            if (r3) begin
                v3 <= v2;
                if (v2) begin
                    id3 <= id2;
                    tag3 <= sum_n >= LIM ? SAT : sum_n[TAG_WIDTH-1:0];
                end
            end
        end
    end

    assign cand_ready = r1;
    assign res_valid  = v3;
    assign res_data   = id3;
    assign res_tag    = tag3;
    assign busy       = v1 || v2 || v3;
endmodule

// File: rtl/distance_enqueuer.sv
// distance_enqueuer: computes candidate distances to a query and enqueues them under credit flow control
module distance_enqueuer
    import knn_pkg::*;
#(
    parameter int DATA_WIDTH  = KNN_DATA_W,
    parameter int TAG_WIDTH   = KNN_TAG_W,
    parameter int COORD_WIDTH = KNN_COORD_W,
    parameter int DIMS        = KNN_DIMS,
    parameter int DEPTH       = KNN_DEPTH
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [DIMS*COORD_WIDTH-1:0] query_in,
    input  logic                        query_load_in,
    input  logic [DATA_WIDTH-1:0]       cand_data_in,
    input  logic [DIMS*COORD_WIDTH-1:0] cand_coord_in,
    input  logic                        cand_valid_in,
    output logic                        cand_ready_out,
    output logic [DATA_WIDTH-1:0]       enq_data_out,
    output logic [TAG_WIDTH-1:0]        enq_tag_out,
    output logic                        enq_out,
    input  logic                        deq_req_in,
    input  logic                        deq_stall_in,
    input  logic                        deq_done_in,
    output logic                        busy_out,
    output logic [15:0]                 result_count_out
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                        armed, pipe_ready, res_valid, busy, fire, load_ok;
    logic [DIMS*COORD_WIDTH-1:0] query;
    logic [CW-1:0]               credits;
    logic [15:0]                 count;

    // a coincident enqueue would make the queue drop its dequeue request
    assign fire    = res_valid && credits != '0 && !deq_req_in && !deq_stall_in && !rst_in;
    assign load_ok = query_load_in && !busy;

    dist_sq_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH),
        .COORD_WIDTH(COORD_WIDTH),
        .DIMS       (DIMS)
    ) u_pipe (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .stall     (!fire),
        .cand_valid(cand_valid_in && armed),
        .cand_data (cand_data_in),
        .cand_coord(cand_coord_in),
        .query     (query),
        .cand_ready(pipe_ready),
        .res_valid (res_valid),
        .res_data  (enq_data_out),
        .res_tag   (enq_tag_out),
        .busy      (busy)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            armed <= 1'b0;
            query <= '0;
            credits <= CW'(DEPTH);
            count <= '0;
        end else begin
            if (load_ok) begin
                armed <= 1'b1;
                query <= query_in;
            end
            count <= load_ok ? '0 : fire ? count + 16'd1 : count;
            credits <= fire && !deq_done_in ? credits - CW'(1)
                     : deq_done_in && !fire && credits != CW'(DEPTH) ? credits + CW'(1)
                     : credits;
        end
    end

    assign cand_ready_out   = armed && pipe_ready && !rst_in;
    assign enq_out          = fire;
    assign busy_out         = busy && !rst_in;
    assign result_count_out = count;
endmodule

// File: tb/tb_distance_enqueuer.sv
// tb_distance_enqueuer: directed vectors with a scoreboard queue checked by an independent enqueue monitor
module tb_distance_enqueuer;
    import knn_pkg::*;

    logic        clk_in = 0, rst_in = 1;
    logic [31:0] query_in = 0, cand_data_in = 0, cand_coord_in = 0;
    logic        query_load_in = 0, cand_valid_in = 0;
    logic        deq_req_in = 0, deq_stall_in = 0, deq_done_in = 0;
    logic        cand_ready_out, enq_out, busy_out;
    logic [31:0] enq_data_out, enq_tag_out;
    logic [15:0] result_count_out;

    distance_enqueuer dut (
        .clk_in(clk_in), .rst_in(rst_in), .query_in(query_in), .query_load_in(query_load_in),
        .cand_data_in(cand_data_in), .cand_coord_in(cand_coord_in), .cand_valid_in(cand_valid_in),
        .cand_ready_out(cand_ready_out), .enq_data_out(enq_data_out), .enq_tag_out(enq_tag_out),
        .enq_out(enq_out), .deq_req_in(deq_req_in), .deq_stall_in(deq_stall_in),
        .deq_done_in(deq_done_in), .busy_out(busy_out), .result_count_out(result_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {logic [31:0] d; logic [31:0] t;} exp_t;
    exp_t sb[$];
    int total = 0, bad = 0, enq_cnt = 0;

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic fail(string n);
        total++;
        bad++;
        $display("FAIL %s: bound expired", n);
    endtask

    function automatic logic [31:0] xy(int x, int y);
        return {16'(y), 16'(x)};
    endfunction

    always @(negedge clk_in) begin
        exp_t e;
        if (enq_out) begin
            enq_cnt++;
            chk("enq_vs_deq_req_stall", {62'd0, deq_req_in, deq_stall_in}, 64'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_enq: got id %0h want none", enq_data_out);
            end else begin
                e = sb.pop_front();
                chk("enq_data", enq_data_out, e.d);
                chk("enq_tag", enq_tag_out, e.t);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic load(int x, int y);
        query_in = xy(x, y);
        query_load_in = 1;
        tick();
        query_load_in = 0;
    endtask

    task automatic send(logic [31:0] id, int x, int y, logic [31:0] tag, bit expect_out);
        bit acc = 0;
        int n = 0;
        cand_data_in = id;
        cand_coord_in = xy(x, y);
        cand_valid_in = 1;
        while (!acc && n < 200) begin
            @(negedge clk_in);
            acc = cand_ready_out;
            tick();
            n++;
        end
        cand_valid_in = 0;
        if (!acc) fail("send_timeout");
        else if (expect_out) sb.push_back('{id, tag});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_out && n < 100) begin
            tick();
            n++;
        end
        if (busy_out) fail("idle_timeout");
    endtask

    task automatic refill();
        deq_done_in = 1;
        repeat (8) tick();
        deq_done_in = 0;
    endtask

    initial begin
        #500000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    initial begin
        int base;
        repeat (3) tick();
        rst_in = 0;
        @(negedge clk_in);
        chk("rst_enq", enq_out, 0);
        chk("rst_data", enq_data_out, 0);
        chk("rst_tag", enq_tag_out, 0);
        chk("rst_ready", cand_ready_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_count", result_count_out, 0);
        tick();

        // basic distance and 3-cycle latency
        load(3, 4);
        cand_data_in = 7;
        cand_coord_in = xy(0, 0);
        cand_valid_in = 1;
        @(negedge clk_in);
        chk("armed_ready", cand_ready_out, 1);
        tick();
        cand_valid_in = 0;
        sb.push_back('{32'd7, 32'd25});
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_in);
            chk($sformatf("latency_cycle%0d", c), enq_out, c == 3);
            tick();
        end
        @(negedge clk_in);
        chk("basic_count", result_count_out, 1);
        tick();

        // other signs and saturation boundary
        wait_idle();
        refill();
        load(0, 0);
        send(11, -3, -4, 25, 1);
        send(12, 1, -1, 2, 1);
        wait_idle();
        load(32767, 32767);
        send(9, -32768, -32768, KNN_SAT_TAG, 1);
        send(10, -32768, 32767, 32'hFFFE0001, 1);
        wait_idle();
        @(negedge clk_in);
        chk("sat_count", result_count_out, 2);
        tick();

        // credits exhaust after 8 enqueues, then return in order
        refill();
        load(0, 0);
        base = enq_cnt;
        for (int i = 0; i < 11; i++) send(100 + i, i, 0, i * i, 1);
        repeat (8) tick();
        @(negedge clk_in);
        chk("credit_enqs", enq_cnt - base, 8);
        chk("credit_ready_fall", cand_ready_out, 0);
        chk("credit_busy", busy_out, 1);
        tick();
        deq_done_in = 1;
        repeat (3) tick();
        deq_done_in = 0;
        repeat (6) tick();
        @(negedge clk_in);
        chk("credit_drain", enq_cnt - base, 11);
        chk("credit_sb_empty", sb.size(), 0);
        tick();

        // dequeue request and stall collisions
        wait_idle();
        refill();
        load(3, 4);
        send(30, 0, 0, 25, 1);
        tick();
        tick();
        deq_req_in = 1;
        @(negedge clk_in);
        chk("req_blocks_enq", enq_out, 0);
        tick();
        deq_req_in = 0;
        @(negedge clk_in);
        chk("req_delay_one", enq_out, 1);
        tick();
        send(31, 3, 0, 16, 1);
        deq_stall_in = 1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_in);
            chk($sformatf("stall_no_enq%0d", c), enq_out, 0);
            tick();
        end
        deq_stall_in = 0;
        @(negedge clk_in);
        chk("stall_release", enq_out, 1);
        tick();

        // query load ignored while busy
        wait_idle();
        send(20, 0, 0, 25, 1);
        @(negedge clk_in);
        chk("guard_busy", busy_out, 1);
        query_in = xy(100, 100);
        query_load_in = 1;
        tick();
        query_load_in = 0;
        send(21, 3, 0, 16, 1);
        wait_idle();
        send(22, 6, 8, 25, 1);
        wait_idle();
        @(negedge clk_in);
        chk("guard_count", result_count_out, 5);
        tick();

        // reset with candidates in flight
        refill();
        deq_stall_in = 1;
        send(40, 1, 1, 0, 0);
        send(41, 2, 2, 0, 0);
        send(42, 3, 3, 0, 0);
        rst_in = 1;
        @(negedge clk_in);
        chk("rst_mid_enq", enq_out, 0);
        tick();
        rst_in = 0;
        deq_stall_in = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_in);
            chk($sformatf("post_rst_enq%0d", c), enq_out, 0);
            chk($sformatf("post_rst_ready%0d", c), cand_ready_out, 0);
            chk($sformatf("post_rst_busy%0d", c), busy_out, 0);
            tick();
        end
        load(0, 0);
        base = enq_cnt;
        for (int i = 0; i < 9; i++) send(50 + i, i, 1, i * i + 1, 1);
        repeat (10) tick();
        @(negedge clk_in);
        chk("post_rst_credits", enq_cnt - base, 8);
        tick();
        deq_done_in = 1;
        tick();
        deq_done_in = 0;
        repeat (4) tick();
        @(negedge clk_in);
        chk("post_rst_last", enq_cnt - base, 9);
        chk("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
